// File: rtl/l1d_ram_pkg.sv
// Shared definitions for the L1D behavioural RAM arrays.
//   - default geometry shared by the L1D bank arrays (data, tag, meta)
//   - calc_aw(): address width helper, max(1, clog2(depth))
//   - be_merge(): merge of one byte lane under its byte enable
package l1d_ram_pkg;

  localparam int unsigned L1D_DEF_WIDTH = 64;
  localparam int unsigned L1D_DEF_DEPTH = 64;

  // A single-entry array still needs a one-bit address port.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Returns new_b where the lane is enabled, old_b otherwise.
  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/pseudo_ram_1r1w_be_if.sv
// Read/write port bundle of the 1R1W byte-enable pseudo RAM.
//   master: requester side (drives requests, receives read data)
//   slave : RAM side
// Signals: rd_en_i, rd_addr_i, rd_data_o, rd_vld_o,
//          wr_en_i, wr_addr_i, wr_be_i, wr_data_i
interface pseudo_ram_1r1w_be_if
  import l1d_ram_pkg::*;
#(
  parameter int unsigned WIDTH = L1D_DEF_WIDTH,
  parameter int unsigned DEPTH = L1D_DEF_DEPTH
);
  localparam int unsigned AW   = calc_aw(DEPTH);
  localparam int unsigned BE_W = WIDTH / 8;

  logic             rd_en_i;
  logic [AW-1:0]    rd_addr_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_vld_o;
  logic             wr_en_i;
  logic [AW-1:0]    wr_addr_i;
  logic [BE_W-1:0]  wr_be_i;
  logic [WIDTH-1:0] wr_data_i;

  modport master (
    output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_be_i, wr_data_i,
    input  rd_data_o, rd_vld_o
  );

  modport slave (
    input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_be_i, wr_data_i,
    output rd_data_o, rd_vld_o
  );

endinterface

// File: rtl/pseudo_ram_rd_pipe.sv
// Read-return pipeline: RD_LAT-deep shift register of {vld, data}.
// Stage 1 captures the read snapshot; the last stage drives the output.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears valids only)
//   in_vld    : read accepted this edge
//   in_data   : snapshot data for that read
//   out_vld   : read data valid
//   out_data  : read data, forced to 0 while out_vld is low
module pseudo_ram_rd_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [RD_LAT-1:0]            vld_q;
  logic [RD_LAT-1:0][WIDTH-1:0] data_q;

  // Clearing the valids drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Data stages carry no reset; the output gate hides stale contents.
  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    for (int i = 1; i < RD_LAT; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  always_comb begin
    out_vld  = vld_q[RD_LAT-1];
    out_data = out_vld ? data_q[RD_LAT-1] : '0;
  end

endmodule

// File: rtl/pseudo_ram_1r1w_be.sv
// Behavioural 1R1W RAM with per-byte write enables and a fixed read latency.
// Parameters: WIDTH (multiple of 8), DEPTH (any), RD_LAT (1..4),
//             BYPASS (same-address collision: 1 = new data, 0 = old data).
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, clears array and read valids
//   bus  : slave side of pseudo_ram_1r1w_be_if (read and write ports)
module pseudo_ram_1r1w_be
  import l1d_ram_pkg::*;
#(
  parameter int unsigned WIDTH  = L1D_DEF_WIDTH,
  parameter int unsigned DEPTH  = L1D_DEF_DEPTH,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  pseudo_ram_1r1w_be_if.slave bus
);

  localparam int unsigned AW   = calc_aw(DEPTH);
  localparam int unsigned BE_W = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             rd_in_range;
  logic             wr_ok;
  logic             collide;
  logic [WIDTH-1:0] rd_old;
  logic [WIDTH-1:0] rd_merged;
  logic [WIDTH-1:0] rd_snap;

  always_comb begin
    rd_in_range = (32'(bus.rd_addr_i) < DEPTH);
    wr_ok       = bus.wr_en_i && (32'(bus.wr_addr_i) < DEPTH);
    collide     = bus.rd_en_i && rd_in_range && wr_ok && (bus.rd_addr_i == bus.wr_addr_i);
  end

  // Out-of-range reads still return a valid beat, carrying zero.
  always_comb begin
    rd_old = '0;
    if (rd_in_range) begin
      rd_old = mem_q[bus.rd_addr_i];
    end
  end

  always_comb begin
    rd_merged = rd_old;
    for (int k = 0; k < int'(BE_W); k++) begin
      rd_merged[8*k +: 8] = be_merge(rd_old[8*k +: 8], bus.wr_data_i[8*k +: 8],
                                     bus.wr_be_i[k]);
    end
  end

  always_comb begin
    rd_snap = rd_old;
    if ((BYPASS != 0) && collide) begin
      rd_snap = rd_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      for (int k = 0; k < int'(BE_W); k++) begin
        if (bus.wr_be_i[k]) begin
          mem_q[bus.wr_addr_i][8*k +: 8] <= bus.wr_data_i[8*k +: 8];
        end
      end
    end
  end

  pseudo_ram_rd_pipe #(
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (bus.rd_en_i),
    .in_data  (rd_snap),
    .out_vld  (bus.rd_vld_o),
    .out_data (bus.rd_data_o)
  );

endmodule

// File: tb/tb_pseudo_ram_1r1w_be.sv
// Drives four RAM configurations in lockstep with the same directed stimulus:
//   u0: RD_LAT=1 BYPASS=1 DEPTH=64    u1: RD_LAT=2 BYPASS=0 DEPTH=48
//   u2: RD_LAT=3 BYPASS=1 DEPTH=48    u3: RD_LAT=4 BYPASS=0 DEPTH=64
// Stimulus pushes {expected data, expected cycle} per instance; a monitor pops
// on every valid beat and checks data, timing and zero-gating.
module tb_pseudo_ram_1r1w_be;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd_en, wr_en;
  logic [5:0]  rd_addr, wr_addr;
  logic [7:0]  wr_be;
  logic [63:0] wr_data;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rst_at = 1 << 30;
  logic mon_en = 1'b0;
  exp_t sb [4][$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  pseudo_ram_1r1w_be_if #(.WIDTH(64), .DEPTH(64)) if0 ();
  pseudo_ram_1r1w_be_if #(.WIDTH(64), .DEPTH(48)) if1 ();
  pseudo_ram_1r1w_be_if #(.WIDTH(64), .DEPTH(48)) if2 ();
  pseudo_ram_1r1w_be_if #(.WIDTH(64), .DEPTH(64)) if3 ();

  pseudo_ram_1r1w_be #(.WIDTH(64), .DEPTH(64), .RD_LAT(1), .BYPASS(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  pseudo_ram_1r1w_be #(.WIDTH(64), .DEPTH(48), .RD_LAT(2), .BYPASS(0))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  pseudo_ram_1r1w_be #(.WIDTH(64), .DEPTH(48), .RD_LAT(3), .BYPASS(1))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  pseudo_ram_1r1w_be #(.WIDTH(64), .DEPTH(64), .RD_LAT(4), .BYPASS(0))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.rd_en_i = rd_en;  assign if0.rd_addr_i = rd_addr;
  assign if0.wr_en_i = wr_en;  assign if0.wr_addr_i = wr_addr;
  assign if0.wr_be_i = wr_be;  assign if0.wr_data_i = wr_data;
  assign if1.rd_en_i = rd_en;  assign if1.rd_addr_i = rd_addr;
  assign if1.wr_en_i = wr_en;  assign if1.wr_addr_i = wr_addr;
  assign if1.wr_be_i = wr_be;  assign if1.wr_data_i = wr_data;
  assign if2.rd_en_i = rd_en;  assign if2.rd_addr_i = rd_addr;
  assign if2.wr_en_i = wr_en;  assign if2.wr_addr_i = wr_addr;
  assign if2.wr_be_i = wr_be;  assign if2.wr_data_i = wr_data;
  assign if3.rd_en_i = rd_en;  assign if3.rd_addr_i = rd_addr;
  assign if3.wr_en_i = wr_en;  assign if3.wr_addr_i = wr_addr;
  assign if3.wr_be_i = wr_be;  assign if3.wr_data_i = wr_data;

  logic [3:0]  vld;
  logic [63:0] dat [4];
  assign vld = {if3.rd_vld_o, if2.rd_vld_o, if1.rd_vld_o, if0.rd_vld_o};
  assign dat[0] = if0.rd_data_o;
  assign dat[1] = if1.rd_data_o;
  assign dat[2] = if2.rd_data_o;
  assign dat[3] = if3.rd_data_o;

  function automatic int lat_of(input int i);
    return i + 1;
  endfunction

  // One clock step; reads are expected RD_LAT-1 cycles after the sampling edge
  // unless a reset lands on or before the edge that would present them.
  task automatic issue(input logic rd, input logic [5:0] ra, input logic wr,
                       input logic [5:0] wa, input logic [7:0] be, input logic [63:0] wd,
                       input logic [63:0] e0, input logic [63:0] e1,
                       input logic [63:0] e2, input logic [63:0] e3);
    int edge_n;
    logic [63:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    rd_en = rd; rd_addr = ra; wr_en = wr; wr_addr = wa; wr_be = be; wr_data = wd;
    edge_n = cyc + 1;
    if (rd) begin
      for (int i = 0; i < 4; i++) begin
        int due;
        due = edge_n + lat_of(i) - 1;
        if (due < rst_at) sb[i].push_back('{data: e[i], due: due});
      end
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rd_all(input logic [5:0] ra, input logic [63:0] e);
    issue(1'b1, ra, 1'b0, 6'd0, 8'h00, 64'h0, e, e, e, e);
  endtask

  task automatic wr_only(input logic [5:0] wa, input logic [7:0] be, input logic [63:0] wd);
    issue(1'b0, 6'd0, 1'b1, wa, be, wd, 64'h0, 64'h0, 64'h0, 64'h0);
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (vld[i] === 1'b1) begin
          total++;
          if (sb[i].size() == 0) begin
            bad++;
            $display("FAIL unexpected_vld u%0d cyc=%0d got data=%h, required no valid beat",
                     i, cyc, dat[i]);
          end else begin
            mon_e = sb[i].pop_front();
            if (mon_e.due != cyc || dat[i] !== mon_e.data) begin
              bad++;
              $display("FAIL rd_beat u%0d got cyc=%0d data=%h, required cyc=%0d data=%h",
                       i, cyc, dat[i], mon_e.due, mon_e.data);
            end
          end
        end else begin
          total++;
          if (vld[i] !== 1'b0 || dat[i] !== 64'h0) begin
            bad++;
            $display("FAIL idle_gate u%0d cyc=%0d got vld=%b data=%h, required vld=0 data=0",
                     i, cyc, vld[i], dat[i]);
          end
          if (sb[i].size() != 0 && sb[i][0].due <= cyc) begin
            total++;
            bad++;
            mon_e = sb[i].pop_front();
            $display("FAIL missing_beat u%0d cyc=%0d got no valid, required data=%h at cyc=%0d",
                     i, cyc, mon_e.data, mon_e.due);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    // Traffic during reset must be ignored.
    wr_en = 1'b1; wr_addr = 6'd3; wr_be = 8'hFF; wr_data = '1; rd_en = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;

    // Back-to-back reads over the whole address space, all zero.
    for (int a = 0; a < 64; a++) rd_all(6'(a), 64'h0);
    idle(6);

    // Full write then lower-half byte-enable write.
    wr_only(6'd5, 8'hFF, 64'h1122334455667788);
    wr_only(6'd5, 8'h0F, {8{8'hAA}});
    rd_all(6'd5, 64'h11223344AAAAAAAA);

    // Same-edge collision on an all-zero entry.
    issue(1'b1, 6'd9, 1'b1, 6'd9, 8'h01, '1,
          64'hFF, 64'h0, 64'hFF, 64'h0);
    rd_all(6'd9, 64'hFF);

    // Sparse lanes, a zero-enable no-op, then a partial collision.
    wr_only(6'd7, 8'hA5, 64'hDEADBEEFCAFEF00D);
    rd_all(6'd7, 64'hDE00BE0000FE000D);
    wr_only(6'd7, 8'h00, '1);
    rd_all(6'd7, 64'hDE00BE0000FE000D);
    issue(1'b1, 6'd7, 1'b1, 6'd7, 8'h0F, 64'h1111111111111111,
          64'hDE00BE0011111111, 64'hDE00BE0000FE000D,
          64'hDE00BE0011111111, 64'hDE00BE0000FE000D);
    rd_all(6'd7, 64'hDE00BE0011111111);

    // A write right after a read must not affect the captured data.
    rd_all(6'd5, 64'h11223344AAAAAAAA);
    wr_only(6'd5, 8'hFF, 64'h0);
    rd_all(6'd5, 64'h0);
    idle(6);

    // Address 50 is out of range only for the DEPTH=48 instances.
    wr_only(6'd50, 8'hFF, {8{8'h55}});
    issue(1'b1, 6'd50, 1'b0, 6'd0, 8'h00, 64'h0,
          {8{8'h55}}, 64'h0, 64'h0, {8{8'h55}});
    rd_all(6'd47, 64'h0);
    rd_all(6'd2, 64'h0);
    idle(6);

    // Reset two edges after the first of two reads.
    rst_at = cyc + 3;
    rd_all(6'd5, 64'h0);
    rd_all(6'd7, 64'hDE00BE0011111111);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rst_at = 1 << 30;
    rd_all(6'd5, 64'h0);
    rd_all(6'd7, 64'h0);
    rd_all(6'd9, 64'h0);
    rd_all(6'd50, 64'h0);
    idle(8);

    for (int i = 0; i < 4; i++) begin
      total++;
      if (sb[i].size() != 0) begin
        bad++;
        $display("FAIL drain u%0d got %0d pending beats, required 0", i, sb[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
